// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   write-back result and a long-latency unit (LU). LU results are buffered in
//   a small FIFO. The pipeline normally has priority. A forced drain (state
//   FORCE, pipeline stalled) happens when the FIFO fills or its head has lost
//   arbitration STARVE_LIMIT cycles in a row.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_pipe_valid/rd/data     pipeline write-back request (held while stalled)
//   i_lu_valid/rd/data       LU result; pushed when i_lu_valid & o_lu_ready
//   o_lu_ready               FIFO has a free slot (registered count only)
//   o_pipe_stall             pipeline must hold WB and everything upstream
//   o_rf_we/rd/data          registered register-file write port
//   o_fifo_count             FIFO occupancy
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_pipe_valid,
    input  logic [ADDR_W-1:0]             i_pipe_rd,
    input  logic [DATA_W-1:0]             i_pipe_data,
    input  logic                          i_lu_valid,
    output logic                          o_lu_ready,
    input  logic [ADDR_W-1:0]             i_lu_rd,
    input  logic [DATA_W-1:0]             i_lu_data,
    output logic                          o_pipe_stall,
    output logic                          o_rf_we,
    output logic [ADDR_W-1:0]             o_rf_rd,
    output logic [DATA_W-1:0]             o_rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = ADDR_W + DATA_W;

    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic              push, pop, grant_pipe;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;

    // Ready is derived from the registered count only, so a pop in the same
    // cycle never frees a slot for a push.
    assign o_lu_ready   = (count_q != COUNT_FULL);
    assign o_pipe_stall = (state_q == FORCE);
    assign o_rf_we      = rf_we_q;
    assign o_rf_rd      = rf_rd_q;
    assign o_rf_data    = rf_data_q;
    assign o_fifo_count = count_q;

    assign {head_rd, head_data} = mem_q[rd_ptr_q];

    always_comb begin
        push       = i_lu_valid && o_lu_ready;
        grant_pipe = 1'b0;
        pop        = 1'b0;
        if (state_q == NORMAL) begin
            grant_pipe = i_pipe_valid;
            pop        = !i_pipe_valid && (count_q != '0);
        end else begin
            pop        = (count_q != '0);
        end

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        // Lost cycles only accumulate while NORMAL holds a waiting head entry.
        starve_d = '0;
        if (state_q == NORMAL && count_q != '0 && !pop)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);

        state_d = state_q;
        if (state_q == NORMAL) begin
            if (count_d == COUNT_FULL || starve_d >= STARVE_MAX)
                state_d = FORCE;
        end else if (count_d == '0) begin
            state_d = NORMAL;
        end

        // Writes to x0 consume the entry but never assert the write enable.
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (grant_pipe) begin
            rf_we_d   = (i_pipe_rd != '0);
            rf_rd_d   = i_pipe_rd;
            rf_data_d = i_pipe_data;
        end else if (pop) begin
            rf_we_d   = (head_rd != '0);
            rf_rd_d   = head_rd;
            rf_data_d = head_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= NORMAL;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {i_lu_rd, i_lu_data};
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pipe_valid = 1'b0;
    logic [ADDR_W-1:0] pipe_rd = '0;
    logic [DATA_W-1:0] pipe_data = '0;
    logic              lu_valid = 1'b0;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_rd = '0;
    logic [DATA_W-1:0] lu_data = '0;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [1:0]        fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_valid(pipe_valid), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
        .i_lu_valid(lu_valid), .o_lu_ready(lu_ready),
        .i_lu_rd(lu_rd), .i_lu_data(lu_data),
        .o_pipe_stall(pipe_stall),
        .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_data(rf_data),
        .o_fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        pipe_valid = v; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic set_lu(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        lu_valid = v; lu_rd = rd; lu_data = d;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [ADDR_W-1:0] rd,
                            input logic [DATA_W-1:0] d);
        check({tag, ".we"}, 64'(rf_we), 64'(we));
        if (we) begin
            check({tag, ".rd"}, 64'(rf_rd), 64'(rd));
            check({tag, ".data"}, 64'(rf_data), 64'(d));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst.count", 64'(fifo_count), 64'd0);
        check("rst.we", 64'(rf_we), 64'd0);
        check("rst.rd", 64'(rf_rd), 64'd0);
        check("rst.data", 64'(rf_data), 64'd0);
        check("rst.stall", 64'(pipe_stall), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst.ready", 64'(lu_ready), 64'd1);

        // Pipe-only write: visible exactly one cycle later
        set_pipe(1, 5'd5, 32'hDEADBEEF);
        check("pipe.stall", 64'(pipe_stall), 64'd0);
        tick();
        set_pipe(0, 0, 0);
        check_wr("pipe.n1", 1, 5'd5, 32'hDEADBEEF);
        check("pipe.stall1", 64'(pipe_stall), 64'd0);
        tick();
        check_wr("pipe.n2", 0, 0, 0);

        // Idle drain: push in N, pop in N+1, write in N+2
        set_lu(1, 5'd7, 32'h12);
        tick();
        set_lu(0, 0, 0);
        check_wr("drain.n1", 0, 0, 0);
        check("drain.count1", 64'(fifo_count), 64'd1);
        tick();
        check_wr("drain.n2", 1, 5'd7, 32'h12);
        check("drain.count2", 64'(fifo_count), 64'd0);
        tick();
        check_wr("drain.n3", 0, 0, 0);

        // x0 suppression for both sources
        set_pipe(1, 5'd0, 32'hAAAA);
        set_lu(1, 5'd0, 32'hBBBB);
        tick();
        set_pipe(0, 0, 0);
        set_lu(0, 0, 0);
        check_wr("x0.pipe", 0, 0, 0);
        check("x0.count1", 64'(fifo_count), 64'd1);
        tick();
        check_wr("x0.lu", 0, 0, 0);
        check("x0.count2", 64'(fifo_count), 64'd0);
        tick();
        check_wr("x0.after", 0, 0, 0);

        // Starvation: one LU entry, pipe busy every cycle
        set_pipe(1, 5'd1, 32'hA1);
        set_lu(1, 5'd2, 32'hB2);
        tick();
        set_lu(0, 0, 0);
        check_wr("starve.c0", 1, 5'd1, 32'hA1);
        check("starve.count", 64'(fifo_count), 64'd1);
        set_pipe(1, 5'd3, 32'hC3);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("starve.nostall", 64'(pipe_stall), 64'd0);
            check_wr("starve.pipe", 1, 5'd3, 32'hC3);
        end
        set_pipe(1, 5'd4, 32'hD4);
        tick();
        check("starve.stall", 64'(pipe_stall), 64'd1);
        check_wr("starve.c4", 1, 5'd4, 32'hD4);
        set_pipe(1, 5'd6, 32'hE6);   // held while stalled
        tick();
        check("starve.unstall", 64'(pipe_stall), 64'd0);
        check_wr("starve.lu", 1, 5'd2, 32'hB2);
        check("starve.count0", 64'(fifo_count), 64'd0);
        tick();
        set_pipe(0, 0, 0);
        check_wr("starve.held", 1, 5'd6, 32'hE6);
        tick();
        check_wr("starve.idle", 0, 0, 0);

        // Full: two pushes under constant pipe traffic, third is back-pressured
        set_pipe(1, 5'd1, 32'h11);
        set_lu(1, 5'd8, 32'h81);
        tick();
        check_wr("full.c0", 1, 5'd1, 32'h11);
        check("full.ready0", 64'(lu_ready), 64'd1);
        set_pipe(1, 5'd9, 32'h92);
        set_lu(1, 5'd10, 32'hA2);
        tick();
        check_wr("full.c1", 1, 5'd9, 32'h92);
        check("full.count2", 64'(fifo_count), 64'd2);
        check("full.ready_lo", 64'(lu_ready), 64'd0);
        check("full.stall1", 64'(pipe_stall), 64'd1);
        set_pipe(1, 5'd11, 32'hB3);
        set_lu(1, 5'd12, 32'hC3);
        tick();
        check_wr("full.pop1", 1, 5'd8, 32'h81);
        check("full.stall2", 64'(pipe_stall), 64'd1);
        check("full.count1", 64'(fifo_count), 64'd1);
        check("full.ready_hi", 64'(lu_ready), 64'd1);
        tick();
        set_lu(0, 0, 0);
        check_wr("full.pop2", 1, 5'd10, 32'hA2);
        check("full.count_pp", 64'(fifo_count), 64'd1);
        check("full.stall3", 64'(pipe_stall), 64'd1);
        tick();
        check_wr("full.pop3", 1, 5'd12, 32'hC3);
        check("full.count0", 64'(fifo_count), 64'd0);
        check("full.unstall", 64'(pipe_stall), 64'd0);
        tick();
        set_pipe(0, 0, 0);
        check_wr("full.held", 1, 5'd11, 32'hB3);
        tick();
        check_wr("full.idle", 0, 0, 0);

        // Reset mid-operation with two entries buffered
        set_pipe(1, 5'd1, 32'h1);
        set_lu(1, 5'd13, 32'hD1);
        tick();
        set_lu(1, 5'd14, 32'hD2);
        tick();
        check("mid.count2", 64'(fifo_count), 64'd2);
        set_pipe(0, 0, 0);
        set_lu(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid.count", 64'(fifo_count), 64'd0);
        check("mid.we", 64'(rf_we), 64'd0);
        check("mid.stall", 64'(pipe_stall), 64'd0);
        check("mid.ready", 64'(lu_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid.nowrite", 64'(rf_we), 64'd0);
        end
        check("mid.count_after", 64'(fifo_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
